// File: rtl/music_box_pkg.sv
// Shared types and sizing for the music box recording path.
package music_box_pkg;

   localparam int unsigned DEFAULT_ADDR_W = 13;
   localparam int unsigned DEFAULT_DATA_W = 8;
   localparam int unsigned DEPTH          = 2 ** DEFAULT_ADDR_W;

   // Recording controller states.
   typedef enum logic [2:0] {
      IDLE,
      REC_WAIT,
      REC_WRITE,
      PLAY_WAIT,
      PLAY_READ,
      PLAY_CAPTURE,
      DONE
   } rec_state_t;

endpackage

// File: rtl/recording_memory_controller_if.sv
// Single-port synchronous RAM port between the recording controller and the RAM.
interface recording_memory_controller_if
   import music_box_pkg::*;
#(
   parameter int unsigned ADDR_W = DEFAULT_ADDR_W,
   parameter int unsigned DATA_W = DEFAULT_DATA_W
);

   logic [ADDR_W-1:0] mem_addr;
   logic              mem_we;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;

   // Controller side: drives address, write enable and write data.
   modport master (
      output mem_addr,
      output mem_we,
      output mem_wdata,
      input  mem_rdata
   );

   // RAM side: returns read data one cycle after the address.
   modport slave (
      input  mem_addr,
      input  mem_we,
      input  mem_wdata,
      output mem_rdata
   );

endinterface

// File: rtl/recording_memory_controller.sv
// Records sample_tick-paced samples into an external RAM and plays them back
// at the same rate. The RAM port is fully registered.
module recording_memory_controller
   import music_box_pkg::*;
#(
   parameter int unsigned ADDR_W = DEFAULT_ADDR_W,
   parameter int unsigned DATA_W = DEFAULT_DATA_W
) (
   input  logic                  clock_50Mhz,
   input  logic                  reset_n,
   input  logic                  mode_record,
   input  logic                  mode_play,
   input  logic                  sample_tick,
   input  logic [DATA_W-1:0]     wr_data,
   output logic [DATA_W-1:0]     rd_data,
   output logic                  rd_valid,
   output logic [ADDR_W:0]       record_length,
   output logic                  rec_full,
   output logic                  play_done,
   output logic                  busy,
   output logic                  overrun,
   recording_memory_controller_if.master mem
);

   // Full-scale pointer value; pointers carry one extra bit so "full" is representable.
   localparam logic [ADDR_W:0] MEM_DEPTH = {1'b1, {ADDR_W{1'b0}}};

   rec_state_t      state;
   rec_state_t      state_next;
   logic [ADDR_W:0] wr_ptr;
   logic [ADDR_W:0] rd_ptr;

   // One-cycle control strobes decoded by the next-state logic.
   logic start_rec;
   logic do_write;
   logic commit_len;
   logic start_play;
   logic do_read;
   logic do_capture;
   logic play_end;
   logic empty_done;
   logic flag_overrun;

   // State register.
   always_ff @(posedge clock_50Mhz or negedge reset_n) begin
      // NOTE: sequential state uses <= so every register samples pre-edge values.
      if (!reset_n) state <= IDLE;
      else          state <= state_next;
   end

   // Next-state decode and control strobes.
   always_comb begin
      // NOTE: every output gets a default first so no path infers a latch.
      state_next   = state;
      start_rec    = 1'b0;
      do_write     = 1'b0;
      commit_len   = 1'b0;
      start_play   = 1'b0;
      do_read      = 1'b0;
      do_capture   = 1'b0;
      play_end     = 1'b0;
      empty_done   = 1'b0;
      flag_overrun = 1'b0;
      case (state)
         IDLE: begin
            if (mode_record) begin
               start_rec  = 1'b1;
               state_next = REC_WAIT;
            end else if (mode_play) begin
               if (record_length == '0) begin
                  empty_done = 1'b1;
                  state_next = DONE;
               end else begin
                  start_play = 1'b1;
                  state_next = PLAY_WAIT;
               end
            end
         end
         REC_WAIT: begin
            // Leaving record mode wins over a coincident tick; length commits here only.
            if (!mode_record) begin
               commit_len = 1'b1;
               state_next = DONE;
            end else if (sample_tick && (wr_ptr < MEM_DEPTH)) begin
               do_write   = 1'b1;
               state_next = REC_WRITE;
            end
         end
         REC_WRITE: begin
            flag_overrun = sample_tick;
            state_next   = REC_WAIT;
         end
         PLAY_WAIT: begin
            if (!mode_play) begin
               state_next = IDLE;
            end else if (sample_tick) begin
               do_read    = 1'b1;
               state_next = PLAY_READ;
            end
         end
         PLAY_READ: begin
            // A read already issued always runs through capture.
            flag_overrun = sample_tick;
            state_next   = PLAY_CAPTURE;
         end
         PLAY_CAPTURE: begin
            flag_overrun = sample_tick;
            do_capture   = 1'b1;
            if (!mode_play) begin
               state_next = IDLE;
            end else if ((rd_ptr + 1'b1) == record_length) begin
               play_end   = 1'b1;
               state_next = DONE;
            end else begin
               state_next = PLAY_WAIT;
            end
         end
         DONE: begin
            // Hold until both modes are released so a held switch cannot retrigger.
            if (!mode_record && !mode_play) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Pointers, committed length, playback outputs and the registered RAM port.
   always_ff @(posedge clock_50Mhz or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr        <= '0;
         rd_ptr        <= '0;
         record_length <= '0;
         rd_data       <= '0;
         rd_valid      <= 1'b0;
         play_done     <= 1'b0;
         overrun       <= 1'b0;
         mem.mem_addr  <= '0;
         mem.mem_we    <= 1'b0;
         mem.mem_wdata <= '0;
      end else begin
         rd_valid   <= 1'b0;
         play_done  <= 1'b0;
         mem.mem_we <= 1'b0;
         if (start_rec)  wr_ptr <= '0;
         if (do_write) begin
            mem.mem_we    <= 1'b1;
            mem.mem_addr  <= wr_ptr[ADDR_W-1:0];
            mem.mem_wdata <= wr_data;
            wr_ptr        <= wr_ptr + 1'b1;
         end
         if (commit_len) record_length <= wr_ptr;
         if (start_play) rd_ptr <= '0;
         if (do_read)    mem.mem_addr <= rd_ptr[ADDR_W-1:0];
         if (do_capture) begin
            rd_data  <= mem.mem_rdata;
            rd_valid <= 1'b1;
            rd_ptr   <= rd_ptr + 1'b1;
         end
         if (play_end || empty_done) play_done <= 1'b1;
         if (flag_overrun)           overrun   <= 1'b1;
      end
   end

   assign rec_full = ((state == REC_WAIT) || (state == REC_WRITE)) && (wr_ptr == MEM_DEPTH);
   assign busy     = (state != IDLE);

endmodule

// File: tb/tb_recording_memory_controller.sv
// Directed bench for the recording memory controller with a behavioural RAM.
module tb_recording_memory_controller;
   import music_box_pkg::*;

   logic        clock_50Mhz = 1'b0;
   logic        reset_n     = 1'b0;
   logic        mode_record = 1'b0;
   logic        mode_play   = 1'b0;
   logic        sample_tick = 1'b0;
   logic [7:0]  wr_data     = '0;
   logic [7:0]  rd_data;
   logic        rd_valid;
   logic [13:0] record_length;
   logic        rec_full;
   logic        play_done;
   logic        busy;
   logic        overrun;

   int n_compared   = 0;
   int n_mismatched = 0;
   int wr_count     = 0;
   int rv_count     = 0;
   int pd_count     = 0;

   recording_memory_controller_if #(.ADDR_W(13), .DATA_W(8)) mem_bus ();

   recording_memory_controller #(.ADDR_W(13), .DATA_W(8)) dut (
      .clock_50Mhz   (clock_50Mhz),
      .reset_n       (reset_n),
      .mode_record   (mode_record),
      .mode_play     (mode_play),
      .sample_tick   (sample_tick),
      .wr_data       (wr_data),
      .rd_data       (rd_data),
      .rd_valid      (rd_valid),
      .record_length (record_length),
      .rec_full      (rec_full),
      .play_done     (play_done),
      .busy          (busy),
      .overrun       (overrun),
      .mem           (mem_bus)
   );

   // 50 MHz clock.
   always #10 clock_50Mhz = ~clock_50Mhz;

   // Behavioural single-port RAM, read data one cycle after the address.
   logic [7:0] ram [DEPTH];
   always @(posedge clock_50Mhz) begin
      // NOTE: the RAM array is deliberately not reset; contents survive a controller reset.
      if (mem_bus.mem_we) ram[mem_bus.mem_addr] <= mem_bus.mem_wdata;
      mem_bus.mem_rdata <= ram[mem_bus.mem_addr];
   end

   // Event counters for writes, read pulses and done pulses.
   always @(posedge clock_50Mhz) begin
      if (mem_bus.mem_we) wr_count <= wr_count + 1;
      if (rd_valid)       rv_count <= rv_count + 1;
      if (play_done)      pd_count <= pd_count + 1;
   end

   typedef struct {
      logic        rec;
      logic        play;
      logic        tick;
      logic [7:0]  wd;
      logic        we;
      logic [12:0] addr;
      logic [7:0]  wdata;
      logic        rv;
      logic [7:0]  rdata;
      logic        pd;
      logic        bsy;
      logic [13:0] len;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t v(input logic rec, play, tick, input logic [7:0] wd,
                              input logic we, input logic [12:0] addr, input logic [7:0] wdata,
                              input logic rv, input logic [7:0] rdata, input logic pd, bsy,
                              input logic [13:0] len);
      vec_t r;
      r.rec = rec; r.play = play; r.tick = tick; r.wd = wd;
      r.we = we; r.addr = addr; r.wdata = wdata; r.rv = rv; r.rdata = rdata;
      r.pd = pd; r.bsy = bsy; r.len = len;
      return r;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_compared++;
      if (act !== exp) begin
         n_mismatched++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic cycle();
      @(posedge clock_50Mhz);
      @(negedge clock_50Mhz);
   endtask

   task automatic drive(input logic rec, play, tick, input logic [7:0] wd);
      mode_record = rec;
      mode_play   = play;
      sample_tick = tick;
      wr_data     = wd;
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      cycle();
      reset_n = 1'b1;
      cycle();
   endtask

   int wr0, rv0, pd0;

   // Main stimulus.
   initial begin
      // Table: record 0x10..0x12, then play them back.
      //          rec play tick wd     we addr   wdata  rv rdata  pd bsy len
      vecs.push_back(v(1, 0, 0, 8'h00, 0, 13'd0, 8'h00, 0, 8'h00, 0, 1, 14'd0));
      vecs.push_back(v(1, 0, 1, 8'h10, 1, 13'd0, 8'h10, 0, 8'h00, 0, 1, 14'd0));
      vecs.push_back(v(1, 0, 0, 8'h00, 0, 13'd0, 8'h10, 0, 8'h00, 0, 1, 14'd0));
      vecs.push_back(v(1, 0, 1, 8'h11, 1, 13'd1, 8'h11, 0, 8'h00, 0, 1, 14'd0));
      vecs.push_back(v(1, 0, 0, 8'h00, 0, 13'd1, 8'h11, 0, 8'h00, 0, 1, 14'd0));
      vecs.push_back(v(1, 0, 1, 8'h12, 1, 13'd2, 8'h12, 0, 8'h00, 0, 1, 14'd0));
      vecs.push_back(v(1, 0, 0, 8'h00, 0, 13'd2, 8'h12, 0, 8'h00, 0, 1, 14'd0));
      vecs.push_back(v(0, 0, 0, 8'h00, 0, 13'd2, 8'h12, 0, 8'h00, 0, 1, 14'd3));
      vecs.push_back(v(0, 0, 0, 8'h00, 0, 13'd2, 8'h12, 0, 8'h00, 0, 0, 14'd3));
      vecs.push_back(v(0, 1, 0, 8'h00, 0, 13'd2, 8'h12, 0, 8'h00, 0, 1, 14'd3));
      vecs.push_back(v(0, 1, 1, 8'h00, 0, 13'd0, 8'h12, 0, 8'h00, 0, 1, 14'd3));
      vecs.push_back(v(0, 1, 0, 8'h00, 0, 13'd0, 8'h12, 0, 8'h00, 0, 1, 14'd3));
      vecs.push_back(v(0, 1, 0, 8'h00, 0, 13'd0, 8'h12, 1, 8'h10, 0, 1, 14'd3));
      vecs.push_back(v(0, 1, 1, 8'h00, 0, 13'd1, 8'h12, 0, 8'h10, 0, 1, 14'd3));
      vecs.push_back(v(0, 1, 0, 8'h00, 0, 13'd1, 8'h12, 0, 8'h10, 0, 1, 14'd3));
      vecs.push_back(v(0, 1, 0, 8'h00, 0, 13'd1, 8'h12, 1, 8'h11, 0, 1, 14'd3));
      vecs.push_back(v(0, 1, 1, 8'h00, 0, 13'd2, 8'h12, 0, 8'h11, 0, 1, 14'd3));
      vecs.push_back(v(0, 1, 0, 8'h00, 0, 13'd2, 8'h12, 0, 8'h11, 0, 1, 14'd3));
      vecs.push_back(v(0, 1, 0, 8'h00, 0, 13'd2, 8'h12, 1, 8'h12, 1, 1, 14'd3));
      vecs.push_back(v(0, 1, 0, 8'h00, 0, 13'd2, 8'h12, 0, 8'h12, 0, 1, 14'd3));
      vecs.push_back(v(0, 0, 0, 8'h00, 0, 13'd2, 8'h12, 0, 8'h12, 0, 0, 14'd3));

      // Reset state, sampled while reset is held.
      @(negedge clock_50Mhz);
      check("reset busy", busy, 0);
      check("reset record_length", record_length, 0);
      check("reset mem_we", mem_bus.mem_we, 0);
      check("reset rd_valid", rd_valid, 0);
      reset_n = 1'b1;
      cycle();

      for (int i = 0; i < vecs.size(); i++) begin
         drive(vecs[i].rec, vecs[i].play, vecs[i].tick, vecs[i].wd);
         cycle();
         check($sformatf("row%0d mem_we", i),        mem_bus.mem_we,    vecs[i].we);
         check($sformatf("row%0d mem_addr", i),      mem_bus.mem_addr,  vecs[i].addr);
         check($sformatf("row%0d mem_wdata", i),     mem_bus.mem_wdata, vecs[i].wdata);
         check($sformatf("row%0d rd_valid", i),      rd_valid,          vecs[i].rv);
         check($sformatf("row%0d rd_data", i),       rd_data,           vecs[i].rdata);
         check($sformatf("row%0d play_done", i),     play_done,         vecs[i].pd);
         check($sformatf("row%0d busy", i),          busy,              vecs[i].bsy);
         check($sformatf("row%0d record_length", i), record_length,     vecs[i].len);
         check($sformatf("row%0d overrun", i),       overrun,           0);
      end

      // Abort playback while a read is in flight: capture completes, no play_done.
      drive(0, 1, 0, 8'h00); cycle();
      drive(0, 1, 1, 8'h00); cycle();
      drive(0, 0, 0, 8'h00); cycle();
      cycle();
      check("abort rd_valid", rd_valid, 1);
      check("abort rd_data", rd_data, 8'h10);
      check("abort play_done", play_done, 0);
      check("abort busy", busy, 0);
      cycle();
      check("abort record_length kept", record_length, 3);

      // Tick on the cycle right after a record tick raises sticky overrun.
      drive(1, 0, 0, 8'h00); cycle();
      wr0 = wr_count;
      drive(1, 0, 1, 8'h20); cycle();
      drive(1, 0, 1, 8'h21); cycle();
      check("overrun set", overrun, 1);
      check("overrun mem_we", mem_bus.mem_we, 0);
      drive(1, 0, 0, 8'h00); cycle(); cycle();
      check("overrun write count", wr_count - wr0, 1);
      check("overrun mem_wdata", mem_bus.mem_wdata, 8'h20);
      drive(0, 0, 0, 8'h00); cycle(); cycle();
      check("overrun sticky", overrun, 1);
      check("overrun length", record_length, 1);
      do_reset();
      check("overrun cleared by reset", overrun, 0);

      // Play with an empty recording.
      wr0 = wr_count; rv0 = rv_count; pd0 = pd_count;
      drive(0, 1, 0, 8'h00); cycle();
      check("empty play_done", play_done, 1);
      check("empty busy", busy, 1);
      cycle();
      check("empty play_done one cycle", play_done, 0);
      check("empty held in done", busy, 1);
      drive(0, 0, 0, 8'h00); cycle();
      check("empty busy released", busy, 0);
      check("empty no writes", wr_count - wr0, 0);
      check("empty no rd_valid", rv_count - rv0, 0);
      check("empty one done", pd_count - pd0, 1);
      check("empty mem_addr", mem_bus.mem_addr, 0);

      // Both modes together record; then reset in the middle of playback.
      drive(1, 1, 0, 8'h00); cycle();
      check("both busy", busy, 1);
      drive(1, 1, 1, 8'h55); cycle();
      check("both mem_we", mem_bus.mem_we, 1);
      check("both mem_wdata", mem_bus.mem_wdata, 8'h55);
      drive(1, 1, 0, 8'h00); cycle();
      drive(0, 0, 0, 8'h00); cycle(); cycle();
      check("both length", record_length, 1);
      drive(0, 1, 0, 8'h00); cycle();
      drive(0, 1, 1, 8'h00); cycle();
      drive(0, 1, 0, 8'h00);
      reset_n = 1'b0;
      #1;
      check("midreset busy", busy, 0);
      check("midreset record_length", record_length, 0);
      check("midreset mem_wdata", mem_bus.mem_wdata, 0);
      check("midreset mem_addr", mem_bus.mem_addr, 0);
      check("midreset mem_we", mem_bus.mem_we, 0);
      check("midreset rd_valid", rd_valid, 0);
      check("midreset rd_data", rd_data, 0);
      check("midreset play_done", play_done, 0);
      check("midreset rec_full", rec_full, 0);
      check("midreset overrun", overrun, 0);
      drive(0, 0, 0, 8'h00);
      @(negedge clock_50Mhz);
      reset_n = 1'b1;
      cycle();

      // Record DEPTH+5 ticks: exactly DEPTH writes, then saturate.
      drive(1, 0, 0, 8'h00); cycle();
      wr0 = wr_count;
      for (int i = 0; i < DEPTH + 5; i++) begin
         drive(1, 0, 1, i[7:0]); cycle();
         sample_tick = 1'b0;
         if (i == DEPTH - 2) check("full not yet", rec_full, 0);
         if (i == DEPTH - 1) begin
            check("full after last write", rec_full, 1);
            check("full last addr", mem_bus.mem_addr, DEPTH - 1);
         end
         cycle(); cycle();
      end
      check("full write count", wr_count - wr0, DEPTH);
      check("full held", rec_full, 1);
      check("full addr unchanged", mem_bus.mem_addr, DEPTH - 1);
      check("full wdata unchanged", mem_bus.mem_wdata, 8'hFF);
      check("full no overrun", overrun, 0);
      drive(0, 0, 0, 8'h00); cycle();
      check("full length", record_length, DEPTH);
      cycle();
      check("full idle", busy, 0);
      check("full flag drops", rec_full, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule

// File: doc/recording_memory_controller.md
RECORDING_MEMORY_CONTROLLER -- requirements
Module: recording_memory_controller

Interface
REQ-001 Parameter ADDR_W, default 13, recording RAM address width; DEPTH = 2**ADDR_W samples (8192).
REQ-002 Parameter DATA_W, default 8, width of one stored sample.
REQ-003 clock_50Mhz  input  1  system clock; all logic on its rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 mode_record  input  1  level; high while the system is in the Make Recording state.
REQ-006 mode_play  input  1  level; high while the system is in the Play Recording state.
REQ-007 sample_tick  input  1  one-cycle strobe at the 1 kHz sample rate, synchronous to clock_50Mhz.
REQ-008 wr_data  input  DATA_W  sample to store; sampled in the sample_tick cycle.
REQ-009 rd_data  output  DATA_W  last sample read during playback; held between reads.
REQ-010 rd_valid  output  1  one-cycle pulse when rd_data updates.
REQ-011 record_length  output  ADDR_W+1  number of samples in the committed recording.
REQ-012 rec_full  output  1  high while recording and wr_ptr == DEPTH.
REQ-013 play_done  output  1  one-cycle pulse when playback completes.
REQ-014 busy  output  1  high in any state other than IDLE.
REQ-015 overrun  output  1  sticky; a sample_tick arrived while a RAM access was in flight.
REQ-016 mem_addr / mem_we / mem_wdata  output  ADDR_W / 1 / DATA_W  single-port synchronous RAM port, all registered.
REQ-017 mem_rdata  input  DATA_W  RAM read data, valid one cycle after mem_addr.

Function
REQ-018 FSM states: IDLE, REC_WAIT, REC_WRITE, PLAY_WAIT, PLAY_READ, PLAY_CAPTURE, DONE.
REQ-019 IDLE, mode_record=1: wr_ptr<=0, go to REC_WAIT; mode_record has priority when both modes are high.
REQ-020 REC_WAIT, sample_tick=1 and wr_ptr<DEPTH: go to REC_WRITE, driving mem_we=1, mem_addr=wr_ptr and mem_wdata=wr_data in the next cycle; wr_ptr increments; return to REC_WAIT.
REQ-021 REC_WAIT, sample_tick=1 and wr_ptr==DEPTH: no write; tick discarded; rec_full stays 1.
REQ-022 REC_WAIT, mode_record=0: record_length<=wr_ptr, go to DONE; the length is committed only on exit.
REQ-023 IDLE, mode_play=1 and mode_record=0, record_length==0: play_done pulses on the next cycle; go to DONE.
REQ-024 IDLE, mode_play=1 and mode_record=0, record_length>0: rd_ptr<=0, go to PLAY_WAIT.
REQ-025 PLAY_WAIT, sample_tick: PLAY_READ drives mem_addr=rd_ptr with mem_we=0, then PLAY_CAPTURE registers rd_data<=mem_rdata; rd_valid is high exactly 3 cycles after the tick cycle; rd_ptr increments.
REQ-026 After a capture with rd_ptr+1 == record_length: play_done pulses in the same cycle as rd_valid; go to DONE; otherwise go to PLAY_WAIT.
REQ-027 mode_play=0 in PLAY_WAIT, PLAY_READ or PLAY_CAPTURE: finish any in-flight capture, go to IDLE, no play_done.
REQ-028 DONE: wait until mode_record=0 and mode_play=0, then go to IDLE; this prevents retrigger.
REQ-029 sample_tick in REC_WRITE, PLAY_READ or PLAY_CAPTURE: tick ignored, overrun<=1; overrun clears only on reset.
REQ-030 mem_we is never high outside REC_WRITE.
REQ-031 Pointer arithmetic is unsigned, ADDR_W+1 bits; no wrap-around; a recording never exceeds DEPTH.
REQ-032 record_length is unchanged by playback; a new recording replaces it.

Reset
REQ-033 While reset_n=0: state=IDLE; wr_ptr, rd_ptr, record_length, rd_data, mem_addr and mem_wdata = 0; rd_valid, play_done, rec_full, busy, overrun and mem_we = 0.
REQ-034 Reset mid-operation discards the recording (record_length=0); RAM contents are not cleared.

Structure
REQ-035 The state enum, DEPTH and the ADDR_W/DATA_W defaults SHALL live in shared package music_box_pkg.
REQ-036 The block SHALL be a single module with no sub-modules; the RAM is instantiated outside the block.

Verification
REQ-037 Record with wr_data=0x10,0x11,0x12 on 3 ticks, then drop mode_record -> three writes at addr 0,1,2 with matching data; record_length=3.
REQ-038 Play after REQ-037 -> rd_data 0x10,0x11,0x12 at tick+3 each; play_done coincides with the third rd_valid; busy drops after mode_play=0.
REQ-039 Record DEPTH+5 ticks -> exactly 8192 writes; rec_full=1 after the 8192nd; record_length=8192.
REQ-040 mode_play with record_length=0 -> play_done pulse 1 cycle later, no mem access, no rd_valid.
REQ-041 Assert mode_record and mode_play together from IDLE -> REC_WAIT entered; deassert reset_n during playback -> all outputs 0, record_length=0.
REQ-042 sample_tick on the cycle after a record tick -> second tick ignored, overrun=1 until reset.
